// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the program-flow controller
package fetch_pkg;
  localparam int PC_W = 12;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - branch-target register file, one write port, one async read port
module branch_lut
  import fetch_pkg::*;
#(
  parameter int D     = PC_W,
  parameter int LUT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [LUT_W-1:0] wr_idx,
  input  logic [D-1:0]     wr_data,
  input  logic [LUT_W-1:0] rd_idx,
  output logic [D-1:0]     rd_data
);
  logic [D-1:0] mem [2**LUT_W];

  // Writes during reset are dropped; reads see the pre-write value in the write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**LUT_W; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - run/halt sequencing, branch/call/return target selection for the PC
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int D         = PC_W,
  parameter int LUT_W     = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [D-1:0]     prog_ctr,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             br_req,
  input  logic             br_cond,
  input  logic             call,
  input  logic             ret,
  input  logic [LUT_W-1:0] br_idx,
  input  logic             lut_wr_en,
  input  logic [LUT_W-1:0] lut_wr_idx,
  input  logic [D-1:0]     lut_wr_data,
  output logic             jump_en,
  output logic [D-1:0]     target,
  output logic             fetch_en,
  output logic             done,
  output logic             ras_err
);
  localparam int RP_W = $clog2(RAS_DEPTH);
  localparam int RC_W = RP_W + 1;

  fetch_state_t    state, state_nxt;
  logic [D-1:0]    ras_mem [RAS_DEPTH];
  logic [RP_W-1:0] ras_ptr;
  logic [RC_W-1:0] ras_cnt;
  logic [D-1:0]    lut_data;
  logic [D-1:0]    ras_top;
  logic [D-1:0]    pc_inc;
  logic            ras_empty, ras_full;
  logic            do_push, do_pop, ras_clr, err_set;

  branch_lut #(.D(D), .LUT_W(LUT_W)) u_lut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (lut_wr_en),
    .wr_idx  (lut_wr_idx),
    .wr_data (lut_wr_data),
    .rd_idx  (br_idx),
    .rd_data (lut_data)
  );

  assign pc_inc    = prog_ctr + 1'b1;
  assign ras_top   = ras_mem[ras_ptr - 1'b1];
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == RC_W'(RAS_DEPTH));

  always_comb begin
    state_nxt = state;
    jump_en   = 1'b1;
    target    = '0;
    fetch_en  = 1'b0;
    done      = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    ras_clr   = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        fetch_en = !stall;
        target   = prog_ctr;
        if (halt_req) begin
          state_nxt = HALTED;
        end else if (!stall) begin
          if (ret && !ras_empty) begin
            do_pop = 1'b1;
            target = ras_top;
          end else if (ret) begin
            err_set = 1'b1;
            jump_en = 1'b0;
          end else if (call) begin
            do_push = 1'b1;
            err_set = ras_full;
            target  = lut_data;
          end else if (br_req && br_cond) begin
            target = lut_data;
          end else begin
            jump_en = 1'b0;
          end
        end
      end
      HALTED: begin
        done   = 1'b1;
        target = prog_ctr;
        if (start) begin
          target    = '0;
          ras_clr   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Full stack keeps the count pinned and lets the write pointer lap the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ras_ptr <= '0;
      ras_cnt <= '0;
      ras_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ras_clr) begin
        ras_ptr <= '0;
        ras_cnt <= '0;
        ras_err <= 1'b0;
      end else begin
        if (err_set) ras_err <= 1'b1;
        if (do_push) begin
          ras_ptr <= ras_ptr + 1'b1;
          if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
        end else if (do_pop) begin
          ras_ptr <= ras_ptr - 1'b1;
          ras_cnt <= ras_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) ras_mem[ras_ptr] <= pc_inc;
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized bench for fetch_ctrl against a queue-based model
module tb_fetch_ctrl;
  localparam int D = 12, LUT_W = 5, RAS_DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic reset, start, stall, halt_req, br_req, br_cond, call, ret, lut_wr_en;
  logic [LUT_W-1:0] br_idx, lut_wr_idx;
  logic [D-1:0] lut_wr_data, prog_ctr, target;
  logic jump_en, fetch_en, done, ras_err;

  int total = 0, bad = 0;

  int m_mode;
  int m_pc;
  int m_lut [32];
  int m_ras [$];
  bit m_err;

  fetch_ctrl #(.D(D), .LUT_W(LUT_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_ctr(prog_ctr), .stall(stall),
    .halt_req(halt_req), .br_req(br_req), .br_cond(br_cond), .call(call), .ret(ret),
    .br_idx(br_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx), .lut_wr_data(lut_wr_data),
    .jump_en(jump_en), .target(target), .fetch_en(fetch_en), .done(done), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  // PC register the controller steers
  always_ff @(posedge clk) begin
    if (reset) prog_ctr <= '0;
    else if (jump_en) prog_ctr <= target;
    else prog_ctr <= prog_ctr + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_err  = 0;
    m_ras.delete();
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic model_step();
    int nxt, lv;
    if (reset) begin
      model_reset();
      return;
    end
    lv  = m_lut[br_idx];
    nxt = m_pc;
    case (m_mode)
      M_IDLE: begin
        nxt = 0;
        if (start) m_mode = M_RUN;
      end
      M_HALT: begin
        if (start) begin
          nxt = 0;
          m_ras.delete();
          m_err  = 0;
          m_mode = M_RUN;
        end
      end
      default: begin
        if (halt_req) m_mode = M_HALT;
        else if (stall) nxt = m_pc;
        else if (ret && m_ras.size() > 0) nxt = m_ras.pop_back();
        else if (ret) begin
          m_err = 1;
          nxt   = m_pc + 1;
        end else if (call) begin
          m_ras.push_back((m_pc + 1) % 4096);
          if (m_ras.size() > RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_err = 1;
          end
          nxt = lv;
        end else if (br_req && br_cond) nxt = lv;
        else nxt = m_pc + 1;
      end
    endcase
    if (lut_wr_en) m_lut[lut_wr_idx] = int'(lut_wr_data);
    m_pc = nxt % 4096;
  endtask

  task automatic clr();
    start = 0; stall = 0; halt_req = 0; br_req = 0; br_cond = 0;
    call = 0; ret = 0; br_idx = '0; lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("pc", prog_ctr, m_pc);
    chk("fetch_en", fetch_en, (m_mode == M_RUN) && !stall);
    chk("done", done, m_mode == M_HALT);
    chk("ras_err", ras_err, m_err);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input int idx, input int data);
    clr(); lut_wr_en = 1; lut_wr_idx = LUT_W'(idx); lut_wr_data = D'(data);
    tick();
  endtask

  task automatic goto_pc(input int addr);
    lut_write(31, addr);
    clr(); br_req = 1; br_cond = 1; br_idx = 5'd31;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    #2;
    chk("rst_jump_en", jump_en, 1);
    chk("rst_target", target, 0);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_done", done, 0);
    chk("rst_ras_err", ras_err, 0);
    chk("rst_pc", prog_ctr, 0);

    // start, then sequential
    clr(); start = 1; tick();
    clr(); tick(); tick();
    chk("seq_pc2", prog_ctr, 2);

    // taken and not-taken branch
    lut_write(3, 'h040);
    goto_pc('h010);
    clr(); br_req = 1; br_cond = 1; br_idx = 5'd3; tick();
    chk("br_taken", prog_ctr, 'h040);
    goto_pc('h010);
    clr(); br_req = 1; br_cond = 0; br_idx = 5'd3; tick();
    chk("br_not_taken", prog_ctr, 'h011);

    // call and return, then overflow
    lut_write(1, 'h200);
    goto_pc('h020);
    clr(); call = 1; br_idx = 5'd1; tick();
    chk("call_pc", prog_ctr, 'h200);
    clr(); tick(); tick();
    clr(); ret = 1; tick();
    chk("ret_pc", prog_ctr, 'h021);
    for (int i = 0; i < 5; i++) begin
      clr(); call = 1; br_idx = 5'd1; tick();
      clr(); tick();
    end
    chk("ras_ovf", ras_err, 1);
    for (int i = 0; i < 4; i++) begin
      clr(); ret = 1; tick();
    end

    // stall and halt priority
    goto_pc('h005);
    clr(); stall = 1;
    #2 chk("stall_fetch_en", fetch_en, 0);
    tick(); tick();
    chk("stall_pc", prog_ctr, 'h005);
    clr(); stall = 1; br_req = 1; br_cond = 1; br_idx = 5'd3; tick();
    chk("stall_br_pc", prog_ctr, 'h005);
    clr(); stall = 1; halt_req = 1; tick();
    chk("halt_done", done, 1);
    clr(); tick(); tick();

    // restart from HALTED, then underflow
    clr(); start = 1; tick();
    chk("restart_pc", prog_ctr, 0);
    chk("restart_err", ras_err, 0);
    clr(); ret = 1; tick();
    chk("unf_err", ras_err, 1);
    chk("unf_pc", prog_ctr, 1);

    // reset during a taken branch
    clr(); br_req = 1; br_cond = 1; br_idx = 5'd3; reset = 1; tick();
    reset = 0;
    chk("rst_br_pc", prog_ctr, 0);
    clr(); start = 1; tick();
    for (int i = 0; i < 32; i++) begin
      clr(); br_req = 1; br_cond = 1; br_idx = LUT_W'(i);
      #2 chk("lut_cleared", target, 0);
      tick();
    end

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      clr();
      reset       = ($urandom_range(199) == 0);
      stall       = ($urandom_range(99) < 15);
      halt_req    = ($urandom_range(99) < 3);
      br_req      = ($urandom_range(99) < 25);
      br_cond     = $urandom_range(1);
      call        = ($urandom_range(99) < 8);
      ret         = ($urandom_range(99) < 10);
      br_idx      = LUT_W'($urandom);
      lut_wr_en   = ($urandom_range(99) < 12);
      lut_wr_idx  = LUT_W'($urandom);
      lut_wr_data = D'($urandom);
      start       = (m_mode != M_RUN) ? ($urandom_range(3) == 0) : ($urandom_range(99) < 5);
      tick();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-flow controller for the 12-bit program counter. It decides each cycle whether the PC register increments, holds, or loads a new address, and drives the PC's `jump_en`/`target` inputs combinationally. It owns the run/halt state machine, a writable branch-target lookup table, and a small return-address stack (RAS) for call/return. It sits between instruction decode and the PC register, ahead of instruction memory.

## Interface
Parameters:
- `D`, 12: PC width in bits.
- `LUT_W`, 5: branch-target index width; the LUT has 2^LUT_W entries.
- `RAS_DEPTH`, 4: return-address stack entries (power of two).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; begins or restarts execution at address 0.
- `prog_ctr`  in  D  current PC register value.
- `stall`  in  1  hold the PC this cycle.
- `halt_req`  in  1  decoded halt instruction.
- `br_req`  in  1  decoded conditional branch.
- `br_cond`  in  1  branch condition; 1 = taken.
- `call`  in  1  decoded call.
- `ret`  in  1  decoded return.
- `br_idx`  in  LUT_W  LUT index, used by branch and call.
- `lut_wr_en`  in  1  LUT write strobe.
- `lut_wr_idx`  in  LUT_W  LUT write index.
- `lut_wr_data`  in  D  LUT write data.
- `jump_en`  out  1  PC load enable.
- `target`  out  D  PC load value.
- `fetch_en`  out  1  instruction at `prog_ctr` is consumed this cycle.
- `done`  out  1  high while HALTED.
- `ras_err`  out  1  sticky RAS overflow or underflow flag.

## Operation
- States: IDLE (reset state), RUN, HALTED. Encoding is 2 bits.
- IDLE:
  - `jump_en=1`, `target=0`, `fetch_en=0`, so the PC is held at 0.
  - `start` moves to RUN.
- RUN: per-cycle priority is `halt_req` > `stall` > `ret` > `call` > taken branch (`br_req & br_cond`) > sequential. Only the highest active request acts.
  - halt: hold (`jump_en=1`, `target=prog_ctr`); next state HALTED.
  - stall: hold; `fetch_en=0`.
  - ret with RAS non-empty: pop; `target` = popped entry.
  - ret with RAS empty: `ras_err` set; treated as sequential.
  - call: push `prog_ctr+1` (mod 2^D); `target=lut[br_idx]`.
  - call with RAS full: the oldest entry is overwritten (circular buffer); `ras_err` set; depth stays at RAS_DEPTH.
  - taken branch: `target=lut[br_idx]`. Not-taken branch is sequential.
  - sequential: `jump_en=0`; the PC self-increments and wraps at 2^D-1 to 0.
- `fetch_en` = RUN & !stall. It stays high during halt and jump cycles.
- HALTED:
  - hold; `done=1`; `fetch_en=0`.
  - `start` jumps to 0 (`jump_en=1`, `target=0`), clears the RAS and `ras_err`, and moves to RUN.
- `start` while in RUN is ignored.
- LUT:
  - 2^LUT_W × D registers, all 0 on reset.
  - Writable in any state. A write is visible from the next cycle.
  - A same-cycle read of the written index returns the old value.
- `ras_err` clears only on reset or on `start` from HALTED.

## Timing
- `jump_en`/`target` are combinational from state, inputs and LUT/RAS registers. The PC takes the new value at the next edge, so a request in cycle n gives `prog_ctr` = target in cycle n+1.
- State, RAS pointer/count, `ras_err` and LUT update on the same edge.
- Reset values: state IDLE, `jump_en=1`, `target=0`, `fetch_en=0`, `done=0`, `ras_err=0`, RAS count 0, all LUT entries 0.
- Reset mid-operation aborts everything. Pending LUT writes in the reset cycle are dropped.
- Reset and `start` in the same cycle: reset wins.

## Structure
- Shared package `fetch_pkg`:
  - `typedef enum logic[1:0] {IDLE, RUN, HALTED} fetch_state_t`
  - PC width constant (12).
- Sub-module `branch_lut`: register-file LUT with one write port and one async read port, parameterised by `D` and `LUT_W`.
- The RAS (array plus pointer and count) stays inline in `fetch_ctrl`.

## Test plan
- Reset, then `start`; idle 3 cycles → PC 0,1,2; `fetch_en=1`; `done=0`.
- Write `lut[3]=0x040`; at PC 0x010 assert `br_req=1`, `br_cond=1`, `br_idx=3` → next PC 0x040. Repeat with `br_cond=0` → next PC 0x011.
- `lut[1]=0x200`; call at PC 0x020 → PC 0x200; ret later → PC 0x021. Five nested calls with `RAS_DEPTH=4` → `ras_err=1`; four returns pop the four newest return addresses.
- `stall` for 2 cycles at PC 0x005 → PC stays 0x005 with `fetch_en=0`. `stall` and `br_req` together → hold. `halt_req` and `stall` together → HALTED with `done=1`.
- In HALTED, pulse `start` → PC 0 next cycle, `ras_err` cleared. `ret` on empty RAS → sequential and `ras_err=1`.
- Reset asserted during a taken-branch cycle → next PC 0, state IDLE, LUT all 0.
